// File: rtl/hangman_host_display.sv
// ---------------------------------------------------------------------------
// hangman_host_display
//   Game host for hangman. Holds the secret word, the revealed-position mask,
//   and the list of wrong letters. It also renders a registered 16x2 LCD image.
//
// Ports
//   clk          system clock, rising edge
//   nRst         asynchronous active-low reset
//   load         one-cycle pulse: start a new game with `word`
//   word         WORD_LEN ASCII chars, char 0 in the MSB byte
//   guess_valid  guess qualifier (accepted when guess_ready is also 1)
//   guess        ASCII guess letter
//   guess_ready  1 while a game is in progress (state == PLAY)
//   state        IDLE=0, PLAY=1, WIN=2, LOSE=3
//   num_correct  number of revealed word positions
//   num_mistake  number of accepted wrong guesses
//   guess_hit    pulse: last accepted guess revealed at least one position
//   guess_miss   pulse: last accepted guess was a new wrong letter
//   disp         LCD image, top row char 0 at [255:248], bottom char 0 at [127:120]
// ---------------------------------------------------------------------------
module hangman_host_display #(
   parameter int WORD_LEN     = 5,
   parameter int MAX_MISTAKES = 6
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  load,
   input  logic [8*WORD_LEN-1:0] word,
   input  logic                  guess_valid,
   input  logic [7:0]            guess,
   output logic                  guess_ready,
   output logic [1:0]            state,
   output logic [4:0]            num_correct,
   output logic [3:0]            num_mistake,
   output logic                  guess_hit,
   output logic                  guess_miss,
   output logic [255:0]          disp
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } state_e;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_BLANK = 8'h5F;
   localparam logic [3:0] MAX_M    = 4'(MAX_MISTAKES);

   // Word/mistake storage is indexed by character position (index 0 = char 0).
   state_e                               state_q, state_d;
   logic [WORD_LEN-1:0][7:0]             word_q, word_d;
   logic [WORD_LEN-1:0]                  rev_q, rev_d;
   logic [MAX_MISTAKES-1:0][7:0]         miss_list_q, miss_list_d;
   logic [3:0]                           num_mistake_q, num_mistake_d;
   logic                                 hit_q, hit_d;
   logic                                 miss_q, miss_d;
   logic [255:0]                         disp_q, disp_d;

   function automatic logic [7:0] to_upper(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
   endfunction

   function automatic logic is_letter(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A);
   endfunction

   // ------------------------------------------------------------------
   // Guess classification against the current game registers
   // ------------------------------------------------------------------
   logic [7:0]          g_up;
   logic                g_letter;
   logic [WORD_LEN-1:0] g_new;     // unrevealed positions holding the letter
   logic                g_any;     // letter occurs anywhere in the word
   logic                g_listed;  // letter already in the mistake list

   always_comb begin
      g_up     = to_upper(guess);
      g_letter = is_letter(g_up);
      g_new    = '0;
      g_any    = 1'b0;
      g_listed = 1'b0;
      for (int c = 0; c < WORD_LEN; c++) begin
         if (word_q[c] == g_up) begin
            g_any = 1'b1;
            if (!rev_q[c]) g_new[c] = 1'b1;
         end
      end
      for (int i = 0; i < MAX_MISTAKES; i++) begin
         if (4'(i) < num_mistake_q && miss_list_q[i] == g_up) g_listed = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Game next-state
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      word_d        = word_q;
      rev_d         = rev_q;
      miss_list_d   = miss_list_q;
      num_mistake_d = num_mistake_q;
      hit_d         = 1'b0;
      miss_d        = 1'b0;

      if (load) begin
         // load overrides everything, including a guess in the same cycle
         for (int c = 0; c < WORD_LEN; c++) begin
            word_d[c] = to_upper(word[8*(WORD_LEN-1-c) +: 8]);
            rev_d[c]  = !is_letter(word_d[c]);
         end
         miss_list_d   = '0;
         num_mistake_d = '0;
         state_d       = ST_PLAY;
      end else if (state_q == ST_PLAY) begin
         if (guess_valid && g_letter) begin
            if (|g_new) begin
               rev_d = rev_q | g_new;
               hit_d = 1'b1;
            end else if (!g_any && !g_listed && num_mistake_q < MAX_M) begin
               for (int i = 0; i < MAX_MISTAKES; i++) begin
                  if (4'(i) == num_mistake_q) miss_list_d[i] = g_up;
               end
               num_mistake_d = num_mistake_q + 4'd1;
               miss_d        = 1'b1;
            end
         end
         // Terminal checks look at the registered values, so WIN/LOSE land
         // one edge after the final reveal / final mistake.
         if (&rev_q)                        state_d = ST_WIN;
         else if (num_mistake_q >= MAX_M)   state_d = ST_LOSE;
      end
   end

   // ------------------------------------------------------------------
   // Display image, built from the current game registers so it trails
   // them by one edge.
   // ------------------------------------------------------------------
   always_comb begin
      logic [63:0] msg;
      disp_d = {32{CH_SPACE}};
      msg    = "YOU WIN!";
      case (state_q)
         ST_PLAY: begin
            for (int c = 0; c < WORD_LEN; c++)
               disp_d[255-8*c -: 8] = rev_q[c] ? word_q[c] : CH_BLANK;
            for (int i = 0; i < MAX_MISTAKES; i++)
               disp_d[127-16*i -: 8] = (4'(i) < num_mistake_q) ? miss_list_q[i] : CH_BLANK;
         end
         ST_WIN, ST_LOSE: begin
            if (state_q == ST_LOSE) msg = "YOU LOSE";
            disp_d[255 -: 64] = msg;
            for (int c = 0; c < WORD_LEN; c++)
               disp_d[127-8*c -: 8] = word_q[c];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q       <= ST_IDLE;
         word_q        <= '0;
         rev_q         <= '0;
         miss_list_q   <= '0;
         num_mistake_q <= '0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
         disp_q        <= '0;
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         rev_q         <= rev_d;
         miss_list_q   <= miss_list_d;
         num_mistake_q <= num_mistake_d;
         hit_q         <= hit_d;
         miss_q        <= miss_d;
         disp_q        <= disp_d;
      end
   end

   // num_correct is a pure function of the mask, so it can never drift.
   always_comb begin
      num_correct = '0;
      for (int c = 0; c < WORD_LEN; c++) num_correct = num_correct + 5'(rev_q[c]);
   end

   assign state       = state_q;
   assign guess_ready = (state_q == ST_PLAY);
   assign num_mistake = num_mistake_q;
   assign guess_hit   = hit_q;
   assign guess_miss  = miss_q;
   assign disp        = disp_q;

endmodule

// File: tb/tb_hangman_host_display.sv
// Directed bench for hangman_host_display: default-size instance (a) plus a
// 16-char / 8-mistake instance (b).
module tb_hangman_host_display;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   // instance a: WORD_LEN=5, MAX_MISTAKES=6
   logic         nrst_a, load_a, gv_a;
   logic [39:0]  word_a;
   logic [7:0]   guess_a;
   logic         ready_a, hit_a, miss_a;
   logic [1:0]   state_a;
   logic [4:0]   ncor_a;
   logic [3:0]   nmis_a;
   logic [255:0] disp_a;

   // instance b: WORD_LEN=16, MAX_MISTAKES=8
   logic         nrst_b, load_b, gv_b;
   logic [127:0] word_b;
   logic [7:0]   guess_b;
   logic         ready_b, hit_b, miss_b;
   logic [1:0]   state_b;
   logic [4:0]   ncor_b;
   logic [3:0]   nmis_b;
   logic [255:0] disp_b;

   int checks = 0;
   int errors = 0;

   hangman_host_display #(.WORD_LEN(5), .MAX_MISTAKES(6)) dut_a (
      .clk(clk), .nRst(nrst_a), .load(load_a), .word(word_a),
      .guess_valid(gv_a), .guess(guess_a), .guess_ready(ready_a),
      .state(state_a), .num_correct(ncor_a), .num_mistake(nmis_a),
      .guess_hit(hit_a), .guess_miss(miss_a), .disp(disp_a));

   hangman_host_display #(.WORD_LEN(16), .MAX_MISTAKES(8)) dut_b (
      .clk(clk), .nRst(nrst_b), .load(load_b), .word(word_b),
      .guess_valid(gv_b), .guess(guess_b), .guess_ready(ready_b),
      .state(state_b), .num_correct(ncor_b), .num_mistake(nmis_b),
      .guess_hit(hit_b), .guess_miss(miss_b), .disp(disp_b));

   function automatic logic [255:0] img(input string top, input string bot);
      logic [255:0] r;
      for (int i = 0; i < 16; i++) begin
         r[255-8*i -: 8] = (i < top.len()) ? top[i] : 8'h20;
         r[127-8*i -: 8] = (i < bot.len()) ? bot[i] : 8'h20;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_w(input logic [39:0] w);
      load_a = 1'b1; word_a = w;
      tick();
      load_a = 1'b0;
   endtask

   task automatic guess_w(input logic [7:0] g);
      gv_a = 1'b1; guess_a = g;
      tick();
      gv_a = 1'b0;
   endtask

   initial begin
      nrst_a = 1'b0; load_a = 1'b0; gv_a = 1'b0; word_a = '0; guess_a = '0;
      nrst_b = 1'b0; load_b = 1'b0; gv_b = 1'b0; word_b = '0; guess_b = '0;
      #2;
      chk("rst_state", 256'(state_a), 256'(0));
      chk("rst_disp", disp_a, 256'(0));
      chk("rst_ready", 256'(ready_a), 256'(0));
      chk("rst_ncor", 256'(ncor_a), 256'(0));
      #10;
      nrst_a = 1'b1; nrst_b = 1'b1;
      tick();
      chk("idle_disp", disp_a, img("", ""));

      // APPLE, guess lowercase p
      load_w("APPLE");
      chk("apple_state", 256'(state_a), 256'(1));
      chk("apple_ready", 256'(ready_a), 256'(1));
      chk("apple_ncor0", 256'(ncor_a), 256'(0));
      guess_w("p");
      chk("p_hit", 256'(hit_a), 256'(1));
      chk("p_miss", 256'(miss_a), 256'(0));
      chk("p_ncor", 256'(ncor_a), 256'(2));
      tick();
      chk("p_hit_drop", 256'(hit_a), 256'(0));
      chk("p_disp", disp_a, img("_PP__", "_ _ _ _ _ _ "));
      guess_w("P");
      chk("p_again_hit", 256'(hit_a), 256'(0));
      chk("p_again_mis", 256'(nmis_a), 256'(0));
      guess_w("5");
      chk("nonletter_miss", 256'(miss_a), 256'(0));
      chk("nonletter_nmis", 256'(nmis_a), 256'(0));

      // hello (lowercase word), Z Q Z
      load_w("hello");
      guess_w("Z");
      chk("z_miss", 256'(miss_a), 256'(1));
      chk("z_nmis", 256'(nmis_a), 256'(1));
      guess_w("q");
      chk("q_nmis", 256'(nmis_a), 256'(2));
      guess_w("Z");
      chk("z2_miss", 256'(miss_a), 256'(0));
      chk("z2_nmis", 256'(nmis_a), 256'(2));
      tick();
      chk("hello_disp", disp_a, img("_____", "Z Q _ _ _ _ "));
      guess_w("l");
      chk("l_ncor", 256'(ncor_a), 256'(2));

      // CAT: lose
      load_w("CAT  ");
      chk("cat_ncor", 256'(ncor_a), 256'(2));
      chk("cat_nmis_clr", 256'(nmis_a), 256'(0));
      guess_w("B"); guess_w("D"); guess_w("E");
      guess_w("F"); guess_w("G"); guess_w("H");
      chk("lose_nmis", 256'(nmis_a), 256'(6));
      chk("lose_still_play", 256'(state_a), 256'(1));
      tick();
      chk("lose_state", 256'(state_a), 256'(3));
      chk("lose_ready", 256'(ready_a), 256'(0));
      guess_w("C");
      chk("lose_ignore_ncor", 256'(ncor_a), 256'(2));
      chk("lose_ignore_hit", 256'(hit_a), 256'(0));
      chk("lose_hold", 256'(state_a), 256'(3));
      chk("lose_disp", disp_a, img("YOU LOSE", "CAT"));

      // CAT: win
      load_w("CAT  ");
      guess_w("C"); guess_w("a"); guess_w("T");
      chk("win_ncor", 256'(ncor_a), 256'(5));
      chk("win_pre_state", 256'(state_a), 256'(1));
      tick();
      chk("win_state", 256'(state_a), 256'(2));
      tick();
      chk("win_disp", disp_a, img("YOU WIN!", "CAT"));

      // load and guess in the same cycle
      load_a = 1'b1; word_a = "ABCDE"; gv_a = 1'b1; guess_a = "A";
      tick();
      load_a = 1'b0; gv_a = 1'b0;
      chk("coll_ncor", 256'(ncor_a), 256'(0));
      chk("coll_hit", 256'(hit_a), 256'(0));
      chk("coll_miss", 256'(miss_a), 256'(0));
      chk("coll_state", 256'(state_a), 256'(1));
      guess_w("A");
      chk("after_coll_ncor", 256'(ncor_a), 256'(1));

      // reset mid-game
      nrst_a = 1'b0;
      #1;
      chk("midrst_state", 256'(state_a), 256'(0));
      chk("midrst_disp", disp_a, 256'(0));
      chk("midrst_ncor", 256'(ncor_a), 256'(0));
      #2 nrst_a = 1'b1;

      // wide instance: A-B padded with '-'
      load_b = 1'b1; word_b = "A-B-------------";
      tick();
      load_b = 1'b0;
      chk("b_ncor", 256'(ncor_b), 256'(14));
      tick();
      chk("b_disp", disp_b, img("_-_-------------", "_ _ _ _ _ _ _ _ "));
      gv_b = 1'b1; guess_b = "b";
      tick();
      gv_b = 1'b0;
      chk("b_hit", 256'(hit_b), 256'(1));
      chk("b_ncor2", 256'(ncor_b), 256'(15));
      nrst_b = 1'b0;
      #1;
      chk("b_rst_state", 256'(state_b), 256'(0));
      chk("b_rst_disp", disp_b, 256'(0));
      chk("b_rst_ncor", 256'(ncor_b), 256'(0));
      #2 nrst_b = 1'b1;
      tick();
      chk("b_idle_disp", disp_b, img("", ""));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
